// File: rtl/fxp_mul_pipe_pkg.sv
// fxp_mul_pipe_pkg: shared fixed-point word format and rounding-mode encodings
package fxp_mul_pipe_pkg;
   localparam int FXP_N            = 16;
   localparam int FXP_FRAC         = 8;
   localparam int FXP_ROUND_FLOOR  = 0;
   localparam int FXP_ROUND_HALFUP = 1;
endpackage

// File: rtl/fxp_mul_pipe_round_sat.sv
// fxp_round_sat: aligns a 2N-bit Q(2*FRAC) product to N bits with optional
// half-up rounding and saturation; ovf flags results outside the N-bit range
module fxp_round_sat
   import fxp_mul_pipe_pkg::*;
#(
   parameter int N     = FXP_N,
   parameter int FRAC  = FXP_FRAC,
   parameter int ROUND = FXP_ROUND_HALFUP,
   parameter int SAT   = 1
) (
   input  logic [2*N-1:0] prod,
   output logic [N-1:0]   y,
   output logic           ovf
);
   localparam logic signed [2*N:0] HALF = (ROUND == FXP_ROUND_HALFUP) ? (2*N+1)'(1) << (FRAC - 1) : '0;
   logic signed [2*N:0] r;
   // one extra bit keeps the rounding carry of the most positive product
   assign r = ($signed({prod[2*N-1], prod}) + HALF) >>> FRAC;
   assign ovf = !((&r[2*N:N-1]) || !(|r[2*N:N-1]));
   assign y = (SAT != 0 && ovf) ? (r[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : r[N-1:0];
endmodule

// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe: stall-all pipelined signed fixed-point multiplier with
// valid/ready handshake, selectable rounding, saturation and sticky overflow
module fxp_mul_pipe
   import fxp_mul_pipe_pkg::*;
#(
   parameter int N     = FXP_N,
   parameter int FRAC  = FXP_FRAC,
   parameter int LAT   = 2,
   parameter int ROUND = FXP_ROUND_HALFUP,
   parameter int SAT   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   y,
   output logic [2*N-1:0] y_full,
   output logic           ovf,
   output logic           ovf_sticky,
   input  logic           ovf_clr
);
   logic                  adv;
   logic [LAT-1:0]        vld;
   logic signed [N-1:0]   a_m, b_m;
   logic signed [2*N-1:0] p_m, p_r;
   logic [N-1:0]          y_d;
   logic                  ovf_d;
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[LAT-1];
   // operand stages: none for LAT=1, one for LAT=2/3, two for LAT=4
   generate
      if (LAT == 1) begin : g_op0
         assign a_m = a;
         assign b_m = b;
      end else if (LAT < 4) begin : g_op1
         always_ff @(posedge clk)
            if (adv) begin
               a_m <= a;
               b_m <= b;
            end
      end else begin : g_op2
         logic signed [N-1:0] a_1, b_1;
         always_ff @(posedge clk)
            if (adv) begin
               a_1 <= a;
               b_1 <= b;
               a_m <= a_1;
               b_m <= b_1;
            end
      end
      assign p_m = (2*N)'(a_m) * (2*N)'(b_m);
      if (LAT >= 3) begin : g_prod
         always_ff @(posedge clk)
            if (adv) p_r <= p_m;
      end else begin : g_noprod
         assign p_r = p_m;
      end
   endgenerate
   fxp_round_sat #(.N(N), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT)) u_rs (
      .prod (p_r),
      .y    (y_d),
      .ovf  (ovf_d)
   );
   // bubbles shift like data so latency stays fixed
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld    <= '0;
         y      <= '0;
         y_full <= '0;
         ovf    <= 1'b0;
      end else if (adv) begin
         vld    <= LAT'({vld, in_valid});
         y      <= y_d;
         y_full <= p_r;
         ovf    <= ovf_d;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ovf_sticky <= 1'b0;
      else if (out_valid && out_ready && ovf) ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
endmodule
